if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch pipeline. Holds the fetch PC, issues requests on the instruction-SRAM request/response interface, and buffers returned instructions in a 2-entry queue toward the decode stage. It is the consumer of the branch/redirect bus and IF flush driven by the execute/memory stage. On a redirect it drops every in-flight and buffered instruction and restarts fetch at the resolved target.

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, credit-limited SRAM requests, 2-entry instruction buffer to decode.
// Optional IF_BUF_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  input  logic [32:0] br_bus,
  input  logic        flush_IF,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] pc;
  logic        started;
  logic [31:0] pq0, pq1;
  logic [1:0]  out_cnt;
  logic [1:0]  cancel_cnt;
  logic [63:0] buf0, buf1;
  logic [1:0]  occ;

  logic        redirect;
  logic [31:0] target;
  logic [2:0]  credit_sum;
  logic        hs;
  logic        resp;
  logic        resp_kept;
  logic [63:0] resp_word;
  logic        buf_push;
  logic        buf_pop;

  assign redirect  = br_bus[32] | flush_IF;
  assign target    = br_bus[31:0] & ~32'h3;

  // cancel never exceeds outstanding, so the subtraction cannot underflow
  assign credit_sum    = {1'b0, out_cnt} - {1'b0, cancel_cnt} + {1'b0, occ};
  assign inst_sram_req = started && !redirect && (out_cnt < 2'd2) && (credit_sum < 3'd2);
  assign inst_sram_addr = pc;

  assign hs        = inst_sram_req && inst_sram_addr_ok;
  assign resp      = inst_sram_data_ok && (out_cnt != 2'd0);
  assign resp_kept = resp && (cancel_cnt == 2'd0) && !redirect;
  assign resp_word = {inst_sram_rdata, pq0};
  assign buf_pop   = (occ != 2'd0) && !redirect && ds_allowin;

`ifdef IF_BUF_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit     = resp_kept && (occ == 2'd0);
  assign fs_to_ds_valid = ((occ != 2'd0) || bypass_hit) && !redirect;
  assign fs_to_ds_bus   = (occ != 2'd0) ? buf0 : resp_word;
  assign buf_push       = resp_kept && !(bypass_hit && ds_allowin);
`else
  assign fs_to_ds_valid = (occ != 2'd0) && !redirect;
  assign fs_to_ds_bus   = buf0;
  assign buf_push       = resp_kept;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      started    <= 1'b0;
      pq0        <= 32'h0;
      pq1        <= 32'h0;
      out_cnt    <= 2'd0;
      cancel_cnt <= 2'd0;
      buf0       <= 64'h0;
      buf1       <= 64'h0;
      occ        <= 2'd0;
    end else begin
      started <= 1'b1;
      // pending-pc queue follows the SRAM protocol even during a redirect
      case ({hs, resp})
        2'b10: if (out_cnt == 2'd0) pq0 <= pc; else pq1 <= pc;
        2'b01: pq0 <= pq1;
        2'b11: pq0 <= pc;
        default: ;
      endcase
      out_cnt <= out_cnt + {1'b0, hs} - {1'b0, resp};

      if (redirect) begin
        pc         <= target;
        occ        <= 2'd0;
        cancel_cnt <= out_cnt - {1'b0, resp};
      end else begin
        if (hs) pc <= pc + 32'd4;
        if (resp && (cancel_cnt != 2'd0)) cancel_cnt <= cancel_cnt - 2'd1;
        case ({buf_push, buf_pop})
          2'b10: begin
            if (occ == 2'd0) buf0 <= resp_word; else buf1 <= resp_word;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            buf0 <= buf1;
            occ  <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              buf0 <= resp_word;
            end else begin
              buf0 <= buf1;
              buf1 <= resp_word;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall, redirects with cancels, mid-transfer reset.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [32:0] br_bus;
  logic        flush_IF;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .br_bus           (br_bus),
    .flush_IF         (flush_IF),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] sram_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] hs_log[$];
  logic        resp_en;
  int          hs_cnt = 0;
  logic        s_req, s_valid, s_aok, s_dok, s_allow;
  logic [31:0] s_addr;
  logic [63:0] s_bus;

  // SRAM contents: a fixed scramble of the word address
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_5a5a;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_resp();
    inst_sram_data_ok = resp_en && (sram_q.size() != 0);
    inst_sram_rdata   = (sram_q.size() != 0) ? inst_of(sram_q[0]) : 32'h0;
  endtask

  // One clock: drive SRAM response, sample at negedge, apply edge effects to the models
  task automatic step();
    drive_resp();
    @(negedge clk);
    s_req   = inst_sram_req;
    s_addr  = inst_sram_addr;
    s_aok   = inst_sram_addr_ok;
    s_dok   = inst_sram_data_ok;
    s_valid = fs_to_ds_valid;
    s_bus   = fs_to_ds_bus;
    s_allow = ds_allowin;
    @(posedge clk);
    #1;
    if (s_dok && sram_q.size() != 0) void'(sram_q.pop_front());
    if (s_req && s_aok) begin
      sram_q.push_back(s_addr);
      hs_log.push_back(s_addr);
      hs_cnt++;
    end
    if (s_valid && s_allow) begin
      got_pc.push_back(s_bus[31:0]);
      got_inst.push_back(s_bus[63:32]);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_inst.delete();
  endtask

  initial begin
    int hs_base;
    reset = 1'b0;
    ds_allowin = 1'b0;
    br_bus = 33'h0;
    flush_IF = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    resp_en = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    check("rst_req", {63'h0, inst_sram_req}, 64'h0);
    check("rst_addr", {32'h0, inst_sram_addr}, {32'h0, RST_PC});
    @(posedge clk);
    #1 reset = 1'b1;
    inst_sram_addr_ok = 1'b1;
    resp_en = 1'b1;
    ds_allowin = 1'b1;
    step();
    check("post_rst_req", {63'h0, s_req}, 64'h0);
    check("post_rst_valid", {63'h0, s_valid}, 64'h0);
    check("post_rst_addr", {32'h0, s_addr}, {32'h0, RST_PC});

    // streaming, then a 10-cycle decode stall, then resume
    steps(20);
    ds_allowin = 1'b0;
    hs_base = hs_cnt;
    steps(10);
    check("stall_hs_le2", {63'h0, (hs_cnt - hs_base) <= 2}, 64'h1);
    check("stall_req", {63'h0, s_req}, 64'h0);
    check("stall_valid", {63'h0, s_valid}, 64'h1);
    ds_allowin = 1'b1;
    steps(20);
    check("stream_count_ge14", {63'h0, got_pc.size() >= 14}, 64'h1);
    for (int i = 0; i < 14; i++) begin
      check($sformatf("stream_pc%0d", i), {32'h0, got_pc[i]}, {32'h0, RST_PC + 32'(4 * i)});
      check($sformatf("stream_inst%0d", i), {32'h0, got_inst[i]}, {32'h0, inst_of(RST_PC + 32'(4 * i))});
    end

    // two outstanding requests, then a branch redirect: both late responses dropped
    resp_en = 1'b0;
    steps(6);
    clear_got();
    br_bus = {1'b1, 32'h1c00_0100};
    step();
    check("br_req_low", {63'h0, s_req}, 64'h0);
    check("br_valid_low", {63'h0, s_valid}, 64'h0);
    br_bus = 33'h0;
    step();
    check("br_addr", {32'h0, s_addr}, 64'h1c00_0100);
    resp_en = 1'b1;
    steps(12);
    check("br_first_pc", {32'h0, got_pc[0]}, 64'h1c00_0100);
    check("br_second_pc", {32'h0, got_pc[1]}, 64'h1c00_0104);
    check("br_second_inst", {32'h0, got_inst[1]}, {32'h0, inst_of(32'h1c00_0104)});

    // redirect coinciding with a response: exactly one more response must be dropped
    resp_en = 1'b0;
    steps(6);
    clear_got();
    br_bus = {1'b1, 32'h1c00_0200};
    resp_en = 1'b1;
    step();
    check("brdok_dok_seen", {63'h0, s_dok}, 64'h1);
    br_bus = 33'h0;
    steps(12);
    check("brdok_first_pc", {32'h0, got_pc[0]}, 64'h1c00_0200);
    check("brdok_second_pc", {32'h0, got_pc[1]}, 64'h1c00_0204);

    // full buffer flushed by flush_IF with an unaligned target
    ds_allowin = 1'b0;
    steps(10);
    check("full_valid", {63'h0, s_valid}, 64'h1);
    check("full_req_low", {63'h0, s_req}, 64'h0);
    clear_got();
    flush_IF = 1'b1;
    br_bus = {1'b0, 32'h1c00_0102};
    step();
    check("flush_valid_low", {63'h0, s_valid}, 64'h0);
    flush_IF = 1'b0;
    br_bus = 33'h0;
    step();
    check("flush_addr_aligned", {32'h0, s_addr}, 64'h1c00_0100);
    check("flush_buf_empty", {63'h0, s_valid}, 64'h0);
    ds_allowin = 1'b1;
    steps(12);
    check("flush_first_pc", {32'h0, got_pc[0]}, 64'h1c00_0100);
    check("flush_first_inst", {32'h0, got_inst[0]}, {32'h0, inst_of(32'h1c00_0100)});

    // asynchronous reset with two requests outstanding
    resp_en = 1'b0;
    steps(6);
    check("pre_rst_outstanding2", {32'h0, sram_q.size()}, 64'd2);
    reset = 1'b0;
    #1;
    check("arst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    check("arst_req", {63'h0, inst_sram_req}, 64'h0);
    check("arst_addr", {32'h0, inst_sram_addr}, {32'h0, RST_PC});
    sram_q.delete();
    hs_log.delete();
    inst_sram_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_got();
    resp_en = 1'b1;
    steps(12);
    check("arst_first_hs", {32'h0, hs_log[0]}, {32'h0, RST_PC});
    check("arst_first_pc", {32'h0, got_pc[0]}, {32'h0, RST_PC});
    check("arst_second_pc", {32'h0, got_pc[1]}, {32'h0, RST_PC + 32'd4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
